// File: rtl/vec_sub_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vec_sub_sched_if                                             |
// | Description : Request, datapath and response bundle for vec_sub_sched.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface vec_sub_sched_if #(
    parameter int DIMENSION = 16,
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2
);
    localparam int c_vec_w = DIMENSION * WIDTH;

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*c_vec_w-1:0] req_data1;
    logic [NREQ*c_vec_w-1:0] req_data2;

    logic                    sub_en;
    logic [c_vec_w-1:0]      sub_data1;
    logic [c_vec_w-1:0]      sub_data2;
    logic [c_vec_w-1:0]      sub_result;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic [c_vec_w-1:0]      rsp_data;

    logic                    busy;

    // Client / datapath environment side
    modport master (
        output req_valid, req_data1, req_data2, rsp_ready, sub_result,
        input  req_ready, rsp_valid, rsp_id, rsp_data, sub_en, sub_data1, sub_data2, busy
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_data1, req_data2, rsp_ready, sub_result,
        output req_ready, rsp_valid, rsp_id, rsp_data, sub_en, sub_data1, sub_data2, busy
    );
endinterface
`default_nettype wire

// File: rtl/vec_sub_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vec_sub_sched                                                |
// | Description : Round-robin scheduler sharing one registered vector          |
// |               subtractor among NREQ requesters. Define                     |
// |               VEC_SUB_SCHED_FIXED_PRIO_EN for lowest-index-wins priority.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module vec_sub_sched #(
    parameter int DIMENSION = 16,
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2
) (
    input  logic           clk,
    input  logic           rst,
    vec_sub_sched_if.slave bus
);
    localparam int c_vec_w = DIMENSION * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               w_any;
    logic [IDW-1:0]     w_gnt;
    logic               w_accept;
    logic [NREQ-1:0]    w_ready;
    logic [c_vec_w-1:0] w_sel1;
    logic [c_vec_w-1:0] w_sel2;

    logic               r_sub_en;
    logic [c_vec_w-1:0] r_op1;
    logic [c_vec_w-1:0] r_op2;
    logic [IDW-1:0]     r_id;
    logic [c_vec_w-1:0] r_rsp_data;
    logic               r_rsp_valid;
    logic               r_busy;

`ifdef VEC_SUB_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_any = 1'b1;
                w_gnt = IDW'(i);
            end
        end
    end
`else
    localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);

    logic [IDW-1:0] r_ptr;
    int             w_dist;
    int             w_best;

    // Winner is the valid requester at the smallest rotated distance from r_ptr.
    always_comb begin
        w_any  = 1'b0;
        w_gnt  = '0;
        w_dist = 0;
        w_best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = i - int'(r_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NREQ;
            end
            if (bus.req_valid[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_any  = 1'b1;
                w_gnt  = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt == c_last_id) ? '0 : w_gnt + IDW'(1);
        end
    end
`endif

    assign w_accept = (r_state == ST_IDLE) && w_any;

    always_comb begin
        w_ready = '0;
        w_sel1  = '0;
        w_sel2  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == IDW'(i)) begin
                w_ready[i] = w_accept;
                w_sel1     = bus.req_data1[i*c_vec_w +: c_vec_w];
                w_sel2     = bus.req_data2[i*c_vec_w +: c_vec_w];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_any) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  w_next = ST_RESP;
            ST_RESP:  if (r_rsp_valid && bus.rsp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are registered from the next-state decision so they line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sub_en    <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_id        <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sub_en    <= w_accept;
            r_rsp_valid <= (w_next == ST_RESP);
            r_busy      <= (w_next != ST_IDLE);
            if (w_accept) begin
                r_op1 <= w_sel1;
                r_op2 <= w_sel2;
                r_id  <= w_gnt;
            end
            if (r_state == ST_WAIT) begin
                r_rsp_data <= bus.sub_result;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.sub_en    = r_sub_en;
    assign bus.sub_data1 = r_op1;
    assign bus.sub_data2 = r_op2;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vec_sub_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vec_sub_sched                                             |
// | Description : Scoreboard bench for vec_sub_sched with a subtractor model.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_vec_sub_sched;
    localparam int DIMENSION = 16;
    localparam int WIDTH     = 8;
    localparam int NREQ      = 4;
    localparam int IDW       = 2;
    localparam int VW        = DIMENSION * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vec_sub_sched_if #(.DIMENSION(DIMENSION), .WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    vec_sub_sched #(.DIMENSION(DIMENSION), .WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [VW-1:0] d1 [NREQ];
    logic [VW-1:0] d2 [NREQ];

    always_comb begin
        bus.req_data1 = '0;
        bus.req_data2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data1[i*VW +: VW] = d1[i];
            bus.req_data2[i*VW +: VW] = d2[i];
        end
    end

    function automatic logic [VW-1:0] exp_sub(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        r = '0;
        for (int l = 0; l < DIMENSION; l++) r[l*WIDTH +: WIDTH] = a[l*WIDTH +: WIDTH] - b[l*WIDTH +: WIDTH];
        return r;
    endfunction

    // Registered subtractor with zero output when idle
    logic [VW-1:0] dp_diff;
    always_comb dp_diff = exp_sub(bus.sub_data1, bus.sub_data2);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bus.sub_result <= '0;
        else      bus.sub_result <= bus.sub_en ? dp_diff : '0;
    end

    typedef struct { int id; logic [VW-1:0] data; } exp_t;
    exp_t sb [$];
    int   gnt_ids [$];
    int   gnt_cyc [$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst) sb.delete();

    always @(negedge clk) begin : monitor
        int   g;
        exp_t e;
        if (rst === 1'b1) begin
            g = -1;
            for (int i = NREQ - 1; i >= 0; i--) if (bus.req_ready[i] && bus.req_valid[i]) g = i;
            if (g >= 0) begin
                checks++;
                if ($countones(bus.req_ready) != 1) begin
                    errors++;
                    $display("FAIL ready_onehot: req_ready=%b, required exactly one bit", bus.req_ready);
                end
                sb.push_back('{id: g, data: exp_sub(d1[g], d2[g])});
                gnt_ids.push_back(g);
                gnt_cyc.push_back(cyc);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_rsp: id=%0d data=%h with nothing outstanding", bus.rsp_id, bus.rsp_data);
                end else begin
                    e = sb.pop_front();
                    if (bus.rsp_id !== IDW'(e.id) || bus.rsp_data !== e.data) begin
                        errors++;
                        $display("FAIL sb_rsp: got id=%0d data=%h, required id=%0d data=%h",
                                 bus.rsp_id, bus.rsp_data, e.id, e.data);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.busy || sb.size() != 0) && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: busy=%b outstanding=%0d, required 0 and 0", bus.busy, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.sub_en, bus.rsp_valid, bus.rsp_id, bus.busy} !== '0 ||
            {bus.sub_data1, bus.sub_data2, bus.rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_held: ready=%b en=%b rv=%b id=%0d busy=%b, required all 0",
                     bus.req_ready, bus.sub_en, bus.rsp_valid, bus.rsp_id, bus.busy);
        end
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.sub_en, bus.rsp_valid, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_release: ready=%b en=%b rv=%b busy=%b, required all 0",
                     bus.req_ready, bus.sub_en, bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        d1[2] = {DIMENSION{8'h10}};
        d2[2] = {DIMENSION{8'h03}};
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready: got %b, required 0100", bus.req_ready);
        end
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus.sub_en !== 1'b1 || bus.sub_data1 !== {DIMENSION{8'h10}} || bus.sub_data2 !== {DIMENSION{8'h03}} ||
            bus.busy !== 1'b1 || bus.req_ready !== 4'b0000) begin
            errors++; $display("FAIL single_issue: en=%b a=%h b=%h busy=%b", bus.sub_en, bus.sub_data1, bus.sub_data2, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.sub_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.sub_data1 !== {DIMENSION{8'h10}}) begin
            errors++; $display("FAIL single_wait: en=%b rv=%b a=%h, required 0 0 and held operand", bus.sub_en, bus.rsp_valid, bus.sub_data1);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== {DIMENSION{8'h0D}}) begin
            errors++; $display("FAIL single_rsp: rv=%b id=%0d data=%h, required 1 2 all-0d", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_done: busy=%b rv=%b, required 0 0", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic run_grants(input logic [NREQ-1:0] mask, input int want[5], input string tag);
        int n = 0;
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int l = 0; l < DIMENSION; l++) begin
                d1[i][l*WIDTH +: WIDTH] = WIDTH'($urandom);
                d2[i][l*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
        gnt_ids.delete();
        gnt_cyc.delete();
        @(posedge clk); #1 bus.req_valid = mask;
        while (gnt_ids.size() < 5 && n < 60) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.req_valid = '0;
        drain();
        checks++;
        if (gnt_ids.size() < 5) begin
            errors++; $display("FAIL %s_count: got %0d grants, required 5", tag, gnt_ids.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (gnt_ids[k] != want[k]) begin
                    errors++; $display("FAIL %s_order[%0d]: got %0d, required %0d", tag, k, gnt_ids[k], want[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (gnt_cyc[k] - gnt_cyc[k-1] != 4) begin
                        errors++; $display("FAIL %s_spacing[%0d]: got %0d cycles, required 4", tag, k, gnt_cyc[k] - gnt_cyc[k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_round_robin();
`ifdef VEC_SUB_SCHED_FIXED_PRIO_EN
        int want[5] = '{0, 0, 0, 0, 0};
`else
        int want[5] = '{0, 1, 2, 3, 0};
`endif
        run_grants(4'b1111, want, "all_four");
    endtask

    task automatic test_fixed_prio();
`ifdef VEC_SUB_SCHED_FIXED_PRIO_EN
        int want[5] = '{1, 1, 1, 1, 1};
`else
        int want[5] = '{1, 3, 1, 3, 1};
`endif
        run_grants(4'b1010, want, "req1_req3");
    endtask

    task automatic test_wrap();
        logic [VW-1:0] want;
        int n;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                d1[1] = {DIMENSION{8'h00}};
                d2[1] = {DIMENSION{8'h01}};
                want  = {DIMENSION{8'hFF}};
                bus.req_valid = 4'b0010;
            end else begin
                for (int l = 0; l < DIMENSION; l++) d1[0][l*WIDTH +: WIDTH] = WIDTH'(l);
                d2[0] = '0;
                want  = d1[0];
                bus.req_valid = 4'b0001;
            end
            n = 0;
            while (bus.req_ready === 4'b0000 && n < 10) begin @(negedge clk); n++; end
            @(posedge clk); #1 bus.req_valid = '0;
            n = 0;
            while (bus.rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== want || bus.rsp_id !== IDW'(1 - c)) begin
                errors++; $display("FAIL wrap_%0d: rv=%b id=%0d data=%h, required data=%h", c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, want);
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] want;
        int n = 0;
        @(posedge clk); #1;
        for (int l = 0; l < DIMENSION; l++) begin
            d1[0][l*WIDTH +: WIDTH] = WIDTH'($urandom);
            d2[0][l*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        want = exp_sub(d1[0], d2[0]);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        while (bus.req_ready === 4'b0000 && n < 10) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.req_valid = 4'b1000;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== want ||
                bus.req_ready !== 4'b0000 || bus.sub_en !== 1'b0 || bus.busy !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: rv=%b id=%0d data=%h ready=%b en=%b, required data=%h",
                                   k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready, bus.sub_en, want);
            end
            @(negedge clk);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 4'b1000) begin
            errors++; $display("FAIL bp_release: busy=%b ready=%b, required 0 1000", bus.busy, bus.req_ready);
        end
        @(posedge clk); #1 bus.req_valid = '0;
        drain();
    endtask

    task automatic test_reset_mid_job();
        int n = 0;
        logic seen_rsp = 1'b0;
        @(posedge clk); #1 bus.req_valid = 4'b0010;
        while (bus.req_ready === 4'b0000 && n < 10) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.req_valid = '0;
        @(posedge clk); #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.sub_en, bus.rsp_valid, bus.rsp_id, bus.busy} !== '0 ||
            {bus.sub_data1, bus.sub_data2, bus.rsp_data} !== '0) begin
            errors++; $display("FAIL midreset_zero: en=%b a=%h rv=%b busy=%b, required all 0", bus.sub_en, bus.sub_data1, bus.rsp_valid, bus.busy);
        end
        @(posedge clk); #2 rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) seen_rsp = 1'b1;
        end
        checks++;
        if (seen_rsp) begin
            errors++; $display("FAIL midreset_dropped: rsp_valid/busy rose after reset, required 0");
        end
        @(posedge clk); #1 bus.req_valid = 4'b0101;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL midreset_ptr: ready=%b, required 0001", bus.req_ready);
        end
        @(posedge clk); #1 bus.req_valid = '0;
        drain();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            d1[i] = '0;
            d2[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_prio();
        test_wrap();
        test_backpressure();
        test_reset_mid_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
